// File: rtl/fp_div_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fp_div_pkg                                                   |
// | Description : Shared states, flag bit positions and qNaN helper for the    |
// |               sequential floating-point divider.                           |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
package fp_div_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_PREP   = 3'd1;
    localparam state_t ST_DIVIDE = 3'd2;
    localparam state_t ST_ROUND  = 3'd3;
    localparam state_t ST_DONE   = 3'd4;

    localparam int FLG_NV = 4;
    localparam int FLG_DZ = 3;
    localparam int FLG_OF = 2;
    localparam int FLG_UF = 1;
    localparam int FLG_NX = 0;

    // Positive quiet NaN: exponent all ones, only the fraction MSB set.
    function automatic logic [127:0] fp_qnan(input int exp_w, input int man_w);
        logic [127:0] v;
        v = '0;
        for (int i = 0; i < exp_w; i++) begin
            v[man_w + i] = 1'b1;
        end
        v[man_w - 1] = 1'b1;
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fp_classify.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fp_classify                                                  |
// | Description : Combinational classification of an IEEE-754 magnitude.      |
// |               Zero exponent counts as zero, so denormals flush.            |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module fp_classify #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic [EXP_W+MAN_W-1:0] i_mag,
    output logic                   o_is_zero,
    output logic                   o_is_inf,
    output logic                   o_is_nan,
    output logic                   o_is_norm
);

    logic [EXP_W-1:0] w_exp;
    logic [MAN_W-1:0] w_frac;
    logic             w_exp_max;

    assign w_exp     = i_mag[EXP_W+MAN_W-1:MAN_W];
    assign w_frac    = i_mag[MAN_W-1:0];
    assign w_exp_max = &w_exp;

    assign o_is_zero = (w_exp == '0);
    assign o_is_inf  = w_exp_max && (w_frac == '0);
    assign o_is_nan  = w_exp_max && (w_frac != '0);
    assign o_is_norm = !o_is_zero && !w_exp_max;

endmodule
`default_nettype wire

// File: rtl/fp_div_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fp_div_seq                                                   |
// | Description : Sequential IEEE-754 divider, radix-2 restoring recurrence,   |
// |               round-to-nearest-even, valid/ready on both sides.            |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module fp_div_seq
    import fp_div_pkg::*;
#(
    parameter  int EXP_W = 8,
    parameter  int MAN_W = 23,
    localparam int W     = 1 + EXP_W + MAN_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a_operand,
    input  logic [W-1:0] b_operand,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] result,
    output logic [4:0]   flags
);

    localparam int                    c_CNT_W   = $clog2(MAN_W + 2);
    localparam logic signed [EXP_W+1:0] c_BIAS  = (EXP_W+2)'(2**(EXP_W-1) - 1);
    localparam logic signed [EXP_W+1:0] c_EMAX  = (EXP_W+2)'(2**EXP_W - 1);
    localparam logic [W-1:0]          c_QNAN    = W'(fp_qnan(EXP_W, MAN_W));
    localparam logic [W-1:0]          c_INF_MAG = {1'b0, {EXP_W{1'b1}}, {MAN_W{1'b0}}};

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [W-1:0]            r_a;
    logic [W-1:0]            r_b;
    logic signed [EXP_W+1:0] r_exp;
    logic [MAN_W:0]          r_mb;
    logic [MAN_W+1:0]        r_rem;
    logic [MAN_W:0]          r_quo;
    logic [c_CNT_W-1:0]      r_cnt;

    logic w_a_zero, w_a_inf, w_a_nan, w_a_norm;
    logic w_b_zero, w_b_inf, w_b_nan, w_b_norm;

    fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_class_a (
        .i_mag     (r_a[W-2:0]),
        .o_is_zero (w_a_zero),
        .o_is_inf  (w_a_inf),
        .o_is_nan  (w_a_nan),
        .o_is_norm (w_a_norm)
    );

    fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_class_b (
        .i_mag     (r_b[W-2:0]),
        .o_is_zero (w_b_zero),
        .o_is_inf  (w_b_inf),
        .o_is_nan  (w_b_nan),
        .o_is_norm (w_b_norm)
    );

    logic                    w_sign;
    logic                    w_special;
    logic [MAN_W:0]          w_ma;
    logic [MAN_W:0]          w_mb;
    logic signed [EXP_W+1:0] w_exp0;

    assign w_sign    = r_a[W-1] ^ r_b[W-1];
    assign w_special = !(w_a_norm && w_b_norm);
    assign w_ma      = {1'b1, r_a[MAN_W-1:0]};
    assign w_mb      = {1'b1, r_b[MAN_W-1:0]};
    assign w_exp0    = $signed({2'b00, r_a[W-2:MAN_W]}) - $signed({2'b00, r_b[W-2:MAN_W]}) + c_BIAS;

    // Operands stay captured until the next accept, so the special result is
    // recomputed from the classifiers when it is latched in ROUND.
    logic [W-1:0] w_spec_res;
    logic [4:0]   w_spec_flg;

    always_comb begin
        w_spec_res = {w_sign, {(W-1){1'b0}}};
        w_spec_flg = '0;
        if (w_a_nan || w_b_nan || (w_a_zero && w_b_zero) || (w_a_inf && w_b_inf)) begin
            w_spec_res         = c_QNAN;
            w_spec_flg[FLG_NV] = 1'b1;
        end else if (w_a_inf) begin
            w_spec_res = {w_sign, c_INF_MAG[W-2:0]};
        end else if (w_b_zero) begin
            w_spec_res         = {w_sign, c_INF_MAG[W-2:0]};
            w_spec_flg[FLG_DZ] = 1'b1;
        end
    end

    // One restoring step: the partial remainder is always below 2*mb.
    logic           w_ge;
    logic [MAN_W:0] w_diff;

    assign w_ge   = (r_rem >= {1'b0, r_mb});
    assign w_diff = w_ge ? (MAN_W+1)'(r_rem - {1'b0, r_mb}) : r_rem[MAN_W:0];

    // r_quo holds fraction and guard; the always-one hidden bit has shifted out,
    // so a carry out of the fraction means the mantissa rounded up to 2.0.
    logic                    w_guard;
    logic                    w_sticky;
    logic                    w_inc;
    logic                    w_fcarry;
    logic [MAN_W-1:0]        w_frac;
    logic signed [EXP_W+1:0] w_exp_r;
    logic [W-1:0]            w_rnd_res;
    logic [4:0]              w_rnd_flg;

    assign w_guard  = r_quo[0];
    assign w_sticky = |r_rem;
    assign w_inc    = w_guard && (w_sticky || r_quo[1]);
    assign {w_fcarry, w_frac} = {1'b0, r_quo[MAN_W:1]} + (MAN_W+1)'(w_inc);
    assign w_exp_r  = r_exp + (EXP_W+2)'(w_fcarry);

    always_comb begin
        w_rnd_res         = {w_sign, w_exp_r[EXP_W-1:0], w_frac};
        w_rnd_flg         = '0;
        w_rnd_flg[FLG_NX] = w_guard || w_sticky;
        if (w_exp_r >= c_EMAX) begin
            w_rnd_res         = {w_sign, c_INF_MAG[W-2:0]};
            w_rnd_flg[FLG_OF] = 1'b1;
            w_rnd_flg[FLG_NX] = 1'b1;
        end else if (w_exp_r[EXP_W+1] || (w_exp_r == '0)) begin
            w_rnd_res         = {w_sign, {(W-1){1'b0}}};
            w_rnd_flg[FLG_UF] = 1'b1;
            w_rnd_flg[FLG_NX] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_state_nxt = ST_PREP;
            end
            // Specials wait in ROUND one cycle so both paths share the output latch.
            ST_PREP:   w_state_nxt = w_special ? ST_ROUND : ST_DIVIDE;
            ST_DIVIDE: if (r_cnt == '0) w_state_nxt = ST_ROUND;
            ST_ROUND:  w_state_nxt = ST_DONE;
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_state_nxt = ST_IDLE;
            end
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a    <= '0;
            r_b    <= '0;
            r_exp  <= '0;
            r_mb   <= '0;
            r_rem  <= '0;
            r_quo  <= '0;
            r_cnt  <= '0;
            result <= '0;
            flags  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_a   <= a_operand;
                        r_b   <= b_operand;
                        flags <= '0;
                    end
                end
                ST_PREP: begin
                    r_mb  <= w_mb;
                    r_quo <= '0;
                    r_cnt <= c_CNT_W'(MAN_W + 1);
                    if (w_ma < w_mb) begin
                        r_rem <= {w_ma, 1'b0};
                        r_exp <= w_exp0 - (EXP_W+2)'(1);
                    end else begin
                        r_rem <= {1'b0, w_ma};
                        r_exp <= w_exp0;
                    end
                end
                ST_DIVIDE: begin
                    r_quo <= {r_quo[MAN_W-1:0], w_ge};
                    r_rem <= {w_diff, 1'b0};
                    r_cnt <= r_cnt - c_CNT_W'(1);
                end
                ST_ROUND: begin
                    result <= w_special ? w_spec_res : w_rnd_res;
                    flags  <= w_special ? w_spec_flg : w_rnd_flg;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fp_div_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_fp_div_seq                                                |
// | Description : Self-checking bench for fp_div_seq: directed cases plus      |
// |               random operands against an integer-arithmetic model.         |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module tb_fp_div_seq;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b0;
    logic        in_valid  = 1'b0;
    logic        in_ready;
    logic [31:0] a_operand = '0;
    logic [31:0] b_operand = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] result;
    logic [4:0]  flags;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fp_div_seq #(.EXP_W(8), .MAN_W(23)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_operand (a_operand),
        .b_operand (b_operand),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flags     (flags)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Exact quotient from integer division, then RNE on the discarded bits.
    function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] res, output logic [4:0] flg,
                                  output bit sp);
        int     ea, eb, e, p, sh;
        bit     s, az, ai, an, bz, bi, bn, inc;
        longint ma, mb, q, rem, mant, rest, half;
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        s  = a[31] ^ b[31];
        az = (ea == 0);
        ai = (ea == 255) && (a[22:0] == 0);
        an = (ea == 255) && (a[22:0] != 0);
        bz = (eb == 0);
        bi = (eb == 255) && (b[22:0] == 0);
        bn = (eb == 255) && (b[22:0] != 0);
        flg = '0;
        sp  = 1'b1;
        if (an || bn || (az && bz) || (ai && bi)) begin
            res = 32'h7FC00000; flg = 5'b10000;
        end else if (ai) begin
            res = {s, 31'h7F800000};
        end else if (bz) begin
            res = {s, 31'h7F800000}; flg = 5'b01000;
        end else if (az || bi) begin
            res = {s, 31'h0};
        end else begin
            sp   = 1'b0;
            ma   = longint'({1'b1, a[22:0]});
            mb   = longint'({1'b1, b[22:0]});
            q    = (ma << 26) / mb;
            rem  = (ma << 26) % mb;
            p    = (q >= (longint'(1) << 26)) ? 26 : 25;
            sh   = p - 23;
            mant = q >> sh;
            rest = q & ((longint'(1) << sh) - 1);
            half = longint'(1) << (sh - 1);
            e    = ea - eb + 127 + p - 26;
            inc  = (rest > half) || ((rest == half) && ((rem != 0) || mant[0]));
            mant = mant + (inc ? 64'd1 : 64'd0);
            if (mant == (longint'(1) << 24)) begin
                mant = mant >> 1;
                e++;
            end
            if (e >= 255) begin
                res = {s, 31'h7F800000}; flg = 5'b00101;
            end else if (e <= 0) begin
                res = {s, 31'h0}; flg = 5'b00011;
            end else begin
                res = {s, 8'(e), 23'(mant)};
                flg = {4'b0000, (rest != 0) || (rem != 0)};
            end
        end
    endfunction

    function automatic logic [31:0] rnd_op();
        logic [7:0]  e;
        logic [22:0] f;
        int          k;
        k = int'($urandom_range(0, 15));
        f = 23'($urandom);
        case (k)
            0:       begin e = 8'd0; f = '0; end
            1:       e = 8'd0;
            2:       begin e = 8'd255; f = '0; end
            3:       begin e = 8'd255; f[0] = 1'b1; end
            4:       e = 8'($urandom_range(1, 8));
            5:       e = 8'($urandom_range(247, 254));
            6, 7:    e = 8'($urandom_range(1, 254));
            default: e = 8'($urandom_range(110, 144));
        endcase
        return {1'($urandom), e, f};
    endfunction

    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] er, input logic [4:0] ef,
                          input bit sp, input int hold);
        int n;
        @(negedge clk);
        a_operand = a;
        b_operand = b;
        in_valid  = 1'b1;
        n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("accept_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        a_operand = $urandom;
        b_operand = $urandom;
        n = 0;
        while (!out_valid && n < 100) begin
            @(posedge clk);
            #1;
            n++;
            in_valid = ($urandom_range(0, 3) == 0);
        end
        chk("latency", 32'(n), sp ? 32'd2 : 32'd27);
        chk("result", result, er);
        chk("flags", 32'(flags), 32'(ef));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            in_valid = 1'($urandom);
            chk("hold_result", result, er);
            chk("hold_flags", 32'(flags), 32'(ef));
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("post_valid", 32'(out_valid), 32'd0);
        chk("post_in_ready", 32'(in_ready), 32'd1);
    endtask

    logic [31:0] dir_a [8] = '{32'h40C00000, 32'h3F800000, 32'hC2140000, 32'h3F800000,
                               32'h00000000, 32'h7F800000, 32'h7F000000, 32'h00800000};
    logic [31:0] dir_b [8] = '{32'h40000000, 32'h40400000, 32'h41880000, 32'h80000000,
                               32'h00000000, 32'h7F800000, 32'h3E800000, 32'h40000000};
    logic [31:0] dir_r [8] = '{32'h40400000, 32'h3EAAAAAB, 32'hC00B4B4B, 32'hFF800000,
                               32'h7FC00000, 32'h7FC00000, 32'h7F800000, 32'h00000000};
    logic [4:0]  dir_f [8] = '{5'b00000, 5'b00001, 5'b00001, 5'b01000,
                               5'b10000, 5'b10000, 5'b00101, 5'b00011};
    bit          dir_s [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

    initial begin
        logic [31:0] a, b, er;
        logic [4:0]  ef;
        bit          sp;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_result", result, 32'd0);
        chk("reset_flags", 32'(flags), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("reset_in_ready", 32'(in_ready), 32'd1);

        for (int i = 0; i < 8; i++) begin
            run_op(dir_a[i], dir_b[i], dir_r[i], dir_f[i], dir_s[i], (i == 1) ? 10 : 0);
        end

        // Abort an operation in the middle of the recurrence.
        @(negedge clk);
        a_operand = 32'h3F800000;
        b_operand = 32'h40400000;
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_result", result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        run_op(32'h40C00000, 32'h40000000, 32'h40400000, 5'b00000, 1'b0, 0);

        for (int i = 0; i < 80; i++) begin
            a = rnd_op();
            b = rnd_op();
            model(a, b, er, ef, sp);
            run_op(a, b, er, ef, sp, int'($urandom_range(0, 3)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
